// File: rtl/abandon_watchdog_if.sv
// Bundle of control/status signals for abandon_watchdog.
// master: the controlling side (drives en/mode/tag/mask/thresholds/cnt_clr).
// slave:  the watchdog (drives clear, clear_pulse, abandon_cnt, busy).
interface abandon_watchdog_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8
);
  logic              en;
  logic              mode;
  logic [N_CH-1:0]   tag;
  logic [N_CH-1:0]   mask;
  logic [CNT_W-1:0]  abandon;
  logic [CNT_W-1:0]  hold;
  logic              cnt_clr;
  logic              clear;
  logic              clear_pulse;
  logic [CNT_W-1:0]  abandon_cnt;
  logic              busy;

  modport master (
    output en, mode, tag, mask, abandon, hold, cnt_clr,
    input  clear, clear_pulse, abandon_cnt, busy
  );

  modport slave (
    input  en, mode, tag, mask, abandon, hold, cnt_clr,
    output clear, clear_pulse, abandon_cnt, busy
  );
endinterface

// File: rtl/abandon_watchdog.sv
// abandon_watchdog: watches N_CH maskable tag channels and raises `clear`
// once the unmasked tags have disagreed for more than `abandon` cycles
// (consecutive or leaky counting), followed by an optional holdoff.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - abandon_watchdog_if.slave: en, mode, tag, mask, abandon, hold,
//            cnt_clr in; clear, clear_pulse, abandon_cnt, busy out
module abandon_watchdog #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  abandon_watchdog_if.slave  bus
);
  localparam int CW1 = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, COUNT, ABANDON, HOLDOFF} state_t;

  state_t           state, state_d;
  logic [CNT_W:0]   cnt, cnt_d;          // one bit wider so abandon = all-ones is reachable
  logic [CNT_W-1:0] hcnt, hcnt_d;
  logic [CNT_W:0]   cnt_inc, cnt_dec, thr;
  logic [N_CH-1:0]  live;
  logic             disagree;

  logic             clear_q, pulse_q, busy_q;
  logic             clear_d, pulse_d, busy_d;
  logic [CNT_W-1:0] evt_q, evt_d;

  assign live     = ~bus.mask;
  assign disagree = (|(bus.tag & live)) && (|(~bus.tag & live));
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CW1'(1);
  assign cnt_dec  = cnt - CW1'(1);
  assign thr      = {1'b0, bus.abandon};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      clear_q <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hcnt    <= hcnt_d;
      clear_q <= clear_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hcnt_d  = hcnt;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (disagree) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc > thr) ? ABANDON : COUNT;
          end
        end
        COUNT: begin
          if (disagree) begin
            cnt_d = cnt_inc;
            if (cnt_inc > thr) state_d = ABANDON;
          end else if (!bus.mode) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) state_d = IDLE;
          end
        end
        ABANDON: begin
          if (!disagree) begin
            cnt_d = '0;
            if (bus.hold != '0) begin
              state_d = HOLDOFF;
              hcnt_d  = CNT_W'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLDOFF: begin
          // >= keeps a live reduction of `hold` from stranding the counter
          if (hcnt >= bus.hold) begin
            state_d = IDLE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Registered-output next values, decoded from the next state
  always_comb begin
    clear_d = (state_d == ABANDON);
    pulse_d = (state_d == ABANDON) && (state != ABANDON);
    busy_d  = (state_d != IDLE);
    evt_d   = evt_q;
    if (bus.cnt_clr)
      evt_d = pulse_d ? CNT_W'(1) : '0;
    else if (pulse_d && (evt_q != '1))
      evt_d = evt_q + CNT_W'(1);
  end

  assign bus.clear       = clear_q;
  assign bus.clear_pulse = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.abandon_cnt = evt_q;
endmodule

// File: tb/tb_abandon_watchdog.sv
// Self-checking bench for abandon_watchdog: directed scenarios plus
// randomized segments, checked each cycle against an integer-level model.
module tb_abandon_watchdog;
  localparam int N_CH    = 3;
  localparam int CNT_W   = 8;
  localparam int RUN_MAX = (1 << (CNT_W + 1)) - 1;
  localparam int EVT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abandon_watchdog_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

  abandon_watchdog #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: disagreement run length, abandon flag,
  // remaining holdoff cycles, event count, entry pulse.
  int run       = 0;
  bit ab        = 1'b0;
  int hold_left = 0;
  int evt       = 0;
  bit m_pulse   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    int ones = 0;
    int zeros = 0;
    bit dis;
    bit entered = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (!bus.mask[i]) begin
        if (bus.tag[i]) ones++;
        else zeros++;
      end
    dis = (ones > 0) && (zeros > 0);
    if (!rst_n) begin
      run = 0; ab = 1'b0; hold_left = 0; evt = 0; m_pulse = 1'b0;
      return;
    end
    if (!bus.en) begin
      run = 0; ab = 1'b0; hold_left = 0;
    end else if (hold_left > 0) begin
      hold_left--;
    end else if (ab) begin
      if (!dis) begin
        ab = 1'b0; run = 0; hold_left = int'(bus.hold);
      end
    end else if (dis) begin
      if (run < RUN_MAX) run++;
      if (run > int'(bus.abandon)) begin
        ab = 1'b1; entered = 1'b1;
      end
    end else if (!bus.mode) begin
      run = 0;
    end else if (run > 0) begin
      run--;
    end
    if (bus.cnt_clr) evt = entered ? 1 : 0;
    else if (entered && evt < EVT_MAX) evt++;
    m_pulse = entered;
  endtask

  // One clock: let the edge sample the current inputs, advance the model,
  // then compare all outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    check("clear", bus.clear, ab);
    check("clear_pulse", bus.clear_pulse, m_pulse);
    check("busy", bus.busy, (ab || hold_left > 0 || run > 0));
    check("abandon_cnt", bus.abandon_cnt, evt);
  endtask

  int ev_before;

  initial begin
    bus.en = 1'b1; bus.mode = 1'b0; bus.tag = '0; bus.mask = '0;
    bus.abandon = 8'd4; bus.hold = '0; bus.cnt_clr = 1'b0;

    // Reset state
    rst_n = 1'b0;
    step();
    check("rst_clear", bus.clear, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_evt", bus.abandon_cnt, 0);
    rst_n = 1'b1;

    // Consecutive mode: abandon=4, 5 disagreeing cycles then agree
    bus.tag = 3'b011;
    repeat (4) step();
    check("consec_edge4_clear", bus.clear, 0);
    step();
    check("consec_edge5_clear", bus.clear, 1);
    check("consec_edge5_pulse", bus.clear_pulse, 1);
    bus.tag = 3'b111;
    step();
    check("consec_edge6_clear", bus.clear, 0);
    check("consec_edge6_pulse", bus.clear_pulse, 0);
    check("consec_evt", bus.abandon_cnt, 1);

    // Masking: masked channel carries the only differing tag
    bus.mask = 3'b100; bus.tag = 3'b100; bus.abandon = 8'd2;
    repeat (20) step();
    check("mask_busy", bus.busy, 0);
    bus.mask = 3'b000;
    repeat (2) step();
    check("unmask_pre", bus.clear, 0);
    step();
    check("unmask_clear", bus.clear, 1);
    bus.tag = 3'b000;
    step();

    // Leaky mode: d d d a d d d stays below abandon=5, one more d fires
    bus.mode = 1'b1; bus.abandon = 8'd5;
    foreach (bus.tag[i]) ;
    for (int i = 0; i < 7; i++) begin
      bus.tag = (i == 3) ? 3'b000 : 3'b010;
      step();
    end
    check("leaky_hold_low", bus.clear, 0);
    bus.tag = 3'b010;
    step();
    check("leaky_fire", bus.clear, 1);
    bus.tag = 3'b000;
    step();
    bus.mode = 1'b0;

    // Holdoff: hold=3, disagreement during holdoff is ignored
    bus.hold = 8'd3; bus.abandon = 8'd0; bus.tag = 3'b010;
    step();
    check("hold_enter", bus.clear, 1);
    bus.tag = 3'b000;
    step();
    check("hold_release_clear", bus.clear, 0);
    check("hold_release_busy", bus.busy, 1);
    bus.abandon = 8'd2; bus.tag = 3'b010;
    repeat (2) step();
    check("hold_busy", bus.busy, 1);
    check("hold_ignored", bus.clear, 0);
    step();
    check("hold_done_busy", bus.busy, 0);
    repeat (2) step();
    check("restart_pre", bus.clear, 0);
    step();
    check("restart_fire", bus.clear, 1);
    bus.hold = '0; bus.tag = 3'b000;
    step();

    // Full threshold with cnt_clr on the entry edge
    bus.abandon = 8'd255; bus.tag = 3'b001;
    repeat (255) step();
    check("full_pre", bus.clear, 0);
    bus.cnt_clr = 1'b1;
    step();
    check("full_fire", bus.clear, 1);
    check("full_clr_evt", bus.abandon_cnt, 1);
    bus.cnt_clr = 1'b0; bus.tag = 3'b000;
    step();

    // Enable drop while abandoned
    bus.abandon = 8'd0; bus.tag = 3'b010;
    step();
    ev_before = evt;
    bus.en = 1'b0;
    step();
    check("en_clear", bus.clear, 0);
    check("en_busy", bus.busy, 0);
    check("en_evt_kept", bus.abandon_cnt, ev_before);
    bus.en = 1'b1;
    step();

    // Reset while abandoned
    rst_n = 1'b0;
    step();
    check("rst_ab_clear", bus.clear, 0);
    check("rst_ab_evt", bus.abandon_cnt, 0);
    check("rst_ab_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Event counter saturation
    bus.abandon = 8'd0;
    repeat (260) begin
      bus.tag = 3'b010; step();
      bus.tag = 3'b000; step();
    end
    check("evt_saturate", bus.abandon_cnt, EVT_MAX);

    // Randomized segments; hold only changes at a forced-idle cycle
    for (int seg = 0; seg < 60; seg++) begin
      bus.hold    = CNT_W'($urandom_range(0, 3));
      bus.mode    = 1'($urandom);
      bus.mask    = N_CH'($urandom);
      bus.abandon = CNT_W'($urandom_range(0, 5));
      bus.en      = 1'b0;
      step();
      bus.en = 1'b1;
      for (int c = 0; c < 50; c++) begin
        bus.tag = ($urandom % 4 == 0) ? 3'b000 : N_CH'($urandom);
        if ($urandom % 8 == 0)  bus.mask    = N_CH'($urandom);
        if ($urandom % 10 == 0) bus.abandon = CNT_W'($urandom_range(0, 6));
        if ($urandom % 20 == 0) bus.mode    = 1'($urandom);
        bus.cnt_clr = ($urandom % 16 == 0);
        bus.en      = ($urandom % 30 != 0);
        rst_n       = ($urandom % 97 != 0);
        step();
      end
      rst_n = 1'b1; bus.cnt_clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
